// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path: opcodes, FSM states,
// ALUOp codes and the decoded instruction-class vector.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_HALT = 7'b0000000;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_ARITH = 2'b10;
    localparam logic [1:0] ALUOP_LUI   = 2'b11;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5
    } state_t;

    // One-hot instruction class; at most one bit set, none for an illegal opcode.
    typedef struct packed {
        logic r;
        logic i;
        logic lw;
        logic sw;
        logic br;
        logic jal;
        logic jalr;
        logic lui;
        logic hlt;
    } op_class_t;

endpackage

// File: rtl/rv_opcode_decode.sv
// Combinational opcode classifier: maps IR[6:0] to a one-hot class vector and
// flags any opcode that is not part of the supported subset.
module rv_opcode_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [8:0] class_o,
    output logic       illegal_o
);

    op_class_t cls;

    always_comb begin
        cls       = '0;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_R:    cls.r    = 1'b1;
            OP_I:    cls.i    = 1'b1;
            OP_LW:   cls.lw   = 1'b1;
            OP_SW:   cls.sw   = 1'b1;
            OP_BR:   cls.br   = 1'b1;
            OP_JAL:  cls.jal  = 1'b1;
            OP_JALR: cls.jalr = 1'b1;
            OP_LUI:  cls.lui  = 1'b1;
            OP_HALT: cls.hlt  = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end

    assign class_o = cls;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I main control FSM with memory handshakes, stall, bounded
// memory wait, illegal-opcode policy and a saturating retired-instruction counter.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter int ILLEGAL_HALT = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             stall,
    output logic             IMemReq,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             jump,
    output logic             jalrSel,
    output logic             RWSel,
    output logic [1:0]       ALUOp,
    output logic             halt,
    output logic             mem_err,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t            state_q, state_d;
    logic [6:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [6:0] dec_op;
    op_class_t  cls;
    logic       illegal;
    logic       wait_last;

    // In DECODE the live IR is classified; later phases use the latched copy.
    assign dec_op = (state_q == DECODE) ? Opcode : op_q;

    rv_opcode_decode u_dec (
        .opcode_i  (dec_op),
        .class_o   (cls),
        .illegal_o (illegal)
    );

    assign wait_last = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        wait_d   = wait_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        IMemReq  = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        jump     = 1'b0;
        jalrSel  = 1'b0;
        RWSel    = 1'b0;
        ALUOp    = ALUOP_MEM;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    IMemReq = 1'b1;
                    if (!stall) begin
                        if (imem_ready) begin
                            IRWrite = 1'b1;
                            state_d = DECODE;
                        end else if (wait_last) begin
                            err_d   = 1'b1;
                            state_d = HALTED;
                        end else if (MEM_TIMEOUT != 0) begin
                            wait_d = wait_q + 1'b1;
                        end
                    end
                end
                DECODE: begin
                    if (!stall) begin
                        op_d = Opcode;
                        if (cls.hlt) begin
                            state_d = HALTED;
                        end else if (illegal) begin
                            if (ILLEGAL_HALT != 0) begin
                                state_d = HALTED;
                            end else begin
                                PCWrite = 1'b1;
                                state_d = FETCH;
                            end
                        end else begin
                            state_d = EXEC;
                        end
                    end
                end
                EXEC: begin
                    ALUSrc = cls.lw | cls.sw | cls.i | cls.lui | cls.jalr;
                    Branch = cls.br;
                    if (cls.br)
                        ALUOp = ALUOP_BR;
                    else if (cls.lui)
                        ALUOp = ALUOP_LUI;
                    else if (cls.r | cls.i | cls.jalr)
                        ALUOp = ALUOP_ARITH;
                    if (!stall) begin
                        if (cls.br) begin
                            PCWrite = 1'b1;
                            state_d = FETCH;
                        end else if (cls.lw | cls.sw) begin
                            state_d = MEM;
                        end else begin
                            state_d = WB;
                        end
                    end
                end
                MEM: begin
                    MemRead  = cls.lw;
                    MemWrite = cls.sw;
                    if (!stall) begin
                        if (dmem_ready) begin
                            if (cls.sw) begin
                                PCWrite = 1'b1;
                                state_d = FETCH;
                            end else begin
                                state_d = WB;
                            end
                        end else if (wait_last) begin
                            err_d   = 1'b1;
                            state_d = HALTED;
                        end else if (MEM_TIMEOUT != 0) begin
                            wait_d = wait_q + 1'b1;
                        end
                    end
                end
                WB: begin
                    MemtoReg = cls.lw;
                    jump     = cls.jal | cls.jalr;
                    RWSel    = cls.jal | cls.jalr;
                    jalrSel  = cls.jalr;
                    if (!stall) begin
                        RegWrite = 1'b1;
                        PCWrite  = 1'b1;
                        state_d  = FETCH;
                    end
                end
                HALTED: state_d = HALTED;
                default: state_d = FETCH;
            endcase
            // Every phase change starts a fresh wait window.
            if (state_d != state_q)
                wait_d = '0;
            if (PCWrite && (cnt_q != '1))
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            op_q    <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign halt        = !reset && (state_q == HALTED);
    assign mem_err     = !reset && err_q;
    assign state_o     = reset ? 3'd0 : state_q;
    assign instr_count = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus pushes per-instruction expectations from a phase-count
// model; a negedge monitor accumulates controls per instruction and compares on retire/halt.
module tb_multicycle_controller;

    localparam int TMO = 4;
    localparam logic [6:0] T_R = 7'b0110011, T_I = 7'b0010011, T_LW = 7'b0000011,
                           T_SW = 7'b0100011, T_BR = 7'b1100011, T_JAL = 7'b1101111,
                           T_JALR = 7'b1100111, T_LUI = 7'b0110111;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  Opcode;
    logic        imem_ready, dmem_ready, stall;
    logic        IMemReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite;
    logic        MemRead, MemWrite, Branch, jump, jalrSel, RWSel;
    logic [1:0]  ALUOp;
    logic        halt, mem_err;
    logic [2:0]  state_o;
    logic [31:0] instr_count;

    multicycle_controller #(.MEM_TIMEOUT(TMO), .ILLEGAL_HALT(0), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .stall(stall), .IMemReq(IMemReq), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .jump(jump),
        .jalrSel(jalrSel), .RWSel(RWSel), .ALUOp(ALUOp), .halt(halt), .mem_err(mem_err),
        .state_o(state_o), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lat; bit hlt; bit err; int irw; int regw; int mr; int mw;
        bit alusrc; int aluop; bit br; bit m2r; bit jmp; bit jalr; int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_fail = 0, done_cnt = 0, model_cnt = 0;
    int   imem_delay = 0, dmem_delay = 0, icnt = 0, dcnt = 0;

    // Memory responders: ready after the chosen number of waiting request cycles.
    assign imem_ready = (icnt >= imem_delay);
    assign dmem_ready = (dcnt >= dmem_delay);

    always @(posedge clk) begin
        if (reset) begin
            icnt <= 0;
            dcnt <= 0;
        end else begin
            icnt <= (IMemReq && !(imem_ready && !stall)) ? icnt + 1 : 0;
            dcnt <= ((MemRead || MemWrite) && !(dmem_ready && !stall)) ? dcnt + 1 : 0;
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: cycles per phase and the controls each instruction class must show.
    function automatic exp_t model(input logic [6:0] op, input int di, input int dd,
                                   input int stl, input int cnt);
        exp_t e;
        e = '{default: 0};
        e.lat = 1 + di + stl; e.irw = 1; e.cnt = cnt;
        case (op)
            T_R:    begin e.lat += 3; e.regw = 1; e.aluop = 2; end
            T_I:    begin e.lat += 3; e.regw = 1; e.aluop = 2; e.alusrc = 1; end
            T_LUI:  begin e.lat += 3; e.regw = 1; e.aluop = 3; e.alusrc = 1; end
            T_JAL:  begin e.lat += 3; e.regw = 1; e.jmp = 1; end
            T_JALR: begin e.lat += 3; e.regw = 1; e.jmp = 1; e.jalr = 1; e.aluop = 2; e.alusrc = 1; end
            T_BR:   begin e.lat += 2; e.br = 1; e.aluop = 1; end
            T_LW:   begin e.lat += 4 + dd; e.regw = 1; e.m2r = 1; e.alusrc = 1; e.mr = dd + 1; end
            T_SW: begin
                e.alusrc = 1;
                if (dd >= TMO) begin
                    e.lat += 2 + TMO + 1; e.hlt = 1; e.err = 1; e.mw = TMO;
                end else begin
                    e.lat += 3 + dd; e.mw = dd + 1;
                end
            end
            7'd0:    begin e.lat += 2; e.hlt = 1; end
            default: e.lat += 1;
        endcase
        return e;
    endfunction

    int  cyc = 0, a_irw = 0, a_regw = 0, a_mr = 0, a_mw = 0, a_aluop = 0;
    bit  a_alusrc = 0, a_br = 0, a_m2r = 0, a_jmp = 0, a_rws = 0, a_jalr = 0, halt_seen = 0;

    task automatic clear_acc();
        cyc = 0; a_irw = 0; a_regw = 0; a_mr = 0; a_mw = 0; a_aluop = 0;
        a_alusrc = 0; a_br = 0; a_m2r = 0; a_jmp = 0; a_rws = 0; a_jalr = 0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_outputs", int'({IMemReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
                MemRead, MemWrite, Branch, jump, jalrSel, RWSel, ALUOp, halt, mem_err, state_o}), 0);
            chk("reset_count", int'(instr_count), 0);
            clear_acc();
            halt_seen = 0;
        end else if (halt_seen) begin
            chk("halt_held", int'({halt, PCWrite, IMemReq, RegWrite}), 8);
        end else begin
            cyc++;
            a_irw += int'(IRWrite); a_regw += int'(RegWrite);
            a_mr += int'(MemRead); a_mw += int'(MemWrite);
            a_aluop |= int'(ALUOp);
            a_alusrc |= ALUSrc; a_br |= Branch; a_m2r |= MemtoReg;
            a_jmp |= jump; a_rws |= RWSel; a_jalr |= jalrSel;
            if (PCWrite || halt) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_event: PCWrite=%0d halt=%0d with empty queue", PCWrite, halt);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("latency", cyc, e.lat);
                    chk("halt", int'(halt), int'(e.hlt));
                    chk("mem_err", int'(mem_err), int'(e.err));
                    chk("irwrite_pulses", a_irw, e.irw);
                    chk("regwrite_pulses", a_regw, e.regw);
                    chk("memread_cycles", a_mr, e.mr);
                    chk("memwrite_cycles", a_mw, e.mw);
                    chk("alusrc", int'(a_alusrc), int'(e.alusrc));
                    chk("aluop", a_aluop, e.aluop);
                    chk("branch", int'(a_br), int'(e.br));
                    chk("memtoreg", int'(a_m2r), int'(e.m2r));
                    chk("jump", int'(a_jmp), int'(e.jmp));
                    chk("rwsel", int'(a_rws), int'(e.jmp));
                    chk("jalrsel", int'(a_jalr), int'(e.jalr));
                    chk("instr_count", int'(instr_count), e.cnt);
                    if (e.hlt) chk("halted_state", int'(state_o), 5);
                end
                if (halt) halt_seen = 1;
                clear_acc();
                done_cnt++;
            end
        end
    end

    task automatic issue(input logic [6:0] op, input int di, input int dd, input int stl);
        exp_t e;
        e = model(op, di, dd, stl, model_cnt);
        Opcode = op; imem_delay = di; dmem_delay = dd;
        exp_q.push_back(e);
        if (!e.hlt) model_cnt++;
    endtask

    task automatic wait_event();
        int prev, g;
        prev = done_cnt; g = 0;
        while (done_cnt == prev && g < 300) begin
            @(posedge clk);
            g++;
        end
        if (done_cnt == prev) begin
            n_chk++; n_fail++;
            $display("FAIL event_timeout: no retire/halt within %0d cycles", g);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        model_cnt = 0;
    endtask

    logic [6:0] optab [9];
    logic [6:0] rop;

    initial begin
        optab = '{T_R, T_I, T_LW, T_SW, T_BR, T_JAL, T_JALR, T_LUI, 7'b1111111};
        reset = 1'b1; stall = 1'b0; Opcode = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        issue(T_R, 0, 0, 0);  wait_event();
        issue(T_LW, 0, 3, 0); wait_event();
        issue(T_BR, 0, 0, 0); wait_event();
        issue(T_I, 0, 0, 2);
        repeat (3) @(posedge clk);
        #1 stall = 1'b1;
        repeat (2) @(posedge clk);
        #1 stall = 1'b0;
        wait_event();
        issue(7'b1111111, 0, 0, 0); wait_event();

        for (int k = 0; k < 40; k++) begin
            rop = optab[$urandom_range(0, 8)];
            if (rop == 7'b1111111) begin
                rop = 7'($urandom_range(1, 127));
                foreach (optab[j]) if (optab[j] == rop) rop = 7'b1111111;
            end
            issue(rop, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
            wait_event();
        end

        // Reset while a load is waiting in MEM: the access must be abandoned.
        issue(T_LW, 0, 3, 0);
        repeat (3) @(posedge clk);
        #1 do_reset();
        issue(T_JALR, 1, 0, 0); wait_event();
        issue(T_SW, 2, 0, 0);   wait_event();

        issue(T_SW, 1, 99, 0); wait_event();
        repeat (4) @(posedge clk);
        #1 do_reset();
        issue(T_LUI, 0, 0, 0); wait_event();
        issue(7'd0, 1, 0, 0);  wait_event();
        repeat (3) @(posedge clk);
        #1 do_reset();
        issue(T_JAL, 0, 0, 0); wait_event();
        issue(T_R, 0, 0, 0);   wait_event();

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
